// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind a fixed-latency,
// handshake-driven read port and an always-available full-word write port.
// The read side accepts a request in IDLE, counts down the remaining latency
// in BUSY, and presents the registered word for exactly one cycle in DONE.
// READ_LAT must lie in 1..15 so that it fits the 4-bit latency counter.
module dmem_responder #(
  parameter int XLEN           = 32,
  parameter int READ_ADDR_SIZE = 32,
  parameter int DEPTH_LOG2     = 10,
  parameter int READ_LAT       = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_readEn,
  input  logic [READ_ADDR_SIZE-1:0] mem_readAddr,
  output logic                      mem_readFin,
  output logic [XLEN-1:0]           mem_radData,
  input  logic                      mem_writeEn,
  input  logic [READ_ADDR_SIZE-1:0] mem_writeAddr,
  input  logic [XLEN-1:0]           mem_writeData
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_INIT = 4'(READ_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;

  logic [XLEN-1:0]       mem_array [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] load_idx;
  logic                  load_en;

  // Byte-offset and high address bits are deliberately ignored, so addresses
  // beyond the array simply wrap onto the same words.
  logic                  unused_addr_bits;

  assign rd_idx           = mem_readAddr[DEPTH_LOG2+1:2];
  assign wr_idx           = mem_writeAddr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{mem_readAddr, mem_writeAddr};

  // Next-state, latency countdown and read-data capture for the read handshake.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rdata_d  = rdata_q;
    load_en  = 1'b0;
    load_idx = idx_q;

    unique case (state_q)
      IDLE: begin
        if (mem_readEn) begin
          idx_d = rd_idx;
          if (READ_LAT == 1) begin
            state_d  = DONE;
            cnt_d    = 4'd0;
            load_en  = 1'b1;
            load_idx = rd_idx;
          end else begin
            state_d = BUSY;
            cnt_d   = LAT_INIT;
          end
        end
      end
      BUSY: begin
        if (!mem_readEn) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = DONE;
            load_en = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (load_en) begin
      if (mem_writeEn && (wr_idx == load_idx)) begin
        rdata_d = mem_writeData;
      end else begin
        rdata_d = mem_array[load_idx];
      end
    end
  end

  // Handshake registers; reset cancels any read in flight and clears the output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array: keeps its contents through reset, but a strobe during reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_writeEn && !rst) begin
      mem_array[wr_idx] <= mem_writeData;
    end
  end

  assign mem_readFin = (state_q == DONE);
  assign mem_radData = rdata_q;

endmodule
